sdc_host_if: RTL and testbench
==============================

// Module: sdc_host_if
// PURPOSE
//  Host-side request front end feeding sdc_top: queues host read/write commands and write data,
//  issues one request at a time on the sdr_req/sdr_req_ack handshake, supplies write beats on
//  sdr_wr_next and returns read beats from sdr_rd_valid. Sits between the host/agent and sdc_top on mclk.
// PARAMETERS
//  CMD_DEPTH  4   command FIFO entries (power of 2, >=2)
//  WD_DEPTH   16  write-data FIFO entries (power of 2, >=4 so one max burst always fits)
// PORTS
//  mclk           in   1             system clock, all logic rising-edge
//  s_resetn       in   1             synchronous, active-low reset
//  hst_cmd_valid  in   1             host command present
//  hst_cmd_ready  out  1             command FIFO not full (registered)
//  hst_cmd_adr    in   U_ADDR_MSB+1  word address
//  hst_cmd_len    in   2             burst length code; beats = len+1 (1..4)
//  hst_cmd_wr_n   in   1             0=write, 1=read
//  hst_wd_valid   in   1             write beat present
//  hst_wd_ready   out  1             write-data FIFO not full (registered)
//  hst_wd_data    in   U_DATA_MSB+1  write beat data
//  hst_wd_en_n    in   4             write beat byte enables, active-low
//  hst_rd_valid   out  1             read beat valid (no backpressure)
//  hst_rd_data    out  U_DATA_MSB+1  read beat data
//  err_underrun   out  1             sticky: sdr_wr_next seen with write-data FIFO empty
//  busy           out  1             FSM not IDLE or command FIFO non-empty
//  sdr_init_done  in   1             controller initialisation complete
//  sdr_req        out  1             request to sdc_top
//  sdr_req_adr    out  U_ADDR_MSB+1  request address
//  sdr_req_len    out  2             request length code
//  sdr_req_wr_n   out  1             request direction
//  sdr_req_ack    in   1             controller accepted request
//  sdr_wr_next    in   1             controller consumes current write beat this cycle
//  sdr_wr_data    out  U_DATA_MSB+1  write-data FIFO head (show-ahead)
//  sdr_wr_en_n    out  4             head byte enables; 4'hF when FIFO empty
//  sdr_rd_valid   in   1             read beat from controller
//  sdr_rd_data    in   U_DATA_MSB+1  read beat data
// BEHAVIOUR
//  Reset (s_resetn=0 at edge): both FIFOs flushed, FSM->IDLE, sdr_req=0, hst_rd_valid=0, hst_rd_data=0,
//   err_underrun=0, ready outputs=0 during reset and 1 the cycle after. Reset mid-burst abandons burst.
//  Push: accept cmd when hst_cmd_valid&hst_cmd_ready; same for wd. Ready from registered count, so a
//   full FIFO refuses push even if popped same cycle.
//  FSM IDLE: if sdr_init_done & cmd FIFO non-empty & (head is read | wd count >= head len+1) -> REQ;
//   load sdr_req_adr/len/wr_n from head, pop cmd, beat counter = len+1.
//  REQ: sdr_req=1, fields stable until sdr_req_ack sampled 1; then sdr_req=0 next cycle,
//   -> WR_BURST or RD_BURST. Ack in first REQ cycle is legal.
//  WR_BURST: each sdr_wr_next pops wd FIFO, decrements counter; counter 1->0 -> IDLE.
//  RD_BURST: each sdr_rd_valid decrements counter; counter 1->0 -> IDLE.
//  Exactly one request outstanding; next request earliest the cycle after returning to IDLE.
//  sdr_wr_data/sdr_wr_en_n combinational from wd head; empty -> data 0, en_n 4'hF.
//  sdr_wr_next with wd empty: no pop, err_underrun set (sticky until reset), counter still decrements.
//  sdr_rd_valid outside RD_BURST: data still forwarded, counter unchanged.
//  Read return: hst_rd_valid/hst_rd_data = sdr_rd_valid/sdr_rd_data registered, latency 1 cycle.
//  FIFO pointers wrap modulo depth; count width clog2(depth)+1.
// STRUCTURE
//  Shared package/define.v: U_ADDR_MSB, U_DATA_MSB (existing); add SDC_LEN_W=2, FSM state encodings
//   (IDLE=2'd0, REQ=2'd1, WR_BURST=2'd2, RD_BURST=2'd3).
//  Sub-module sdc_sync_fifo (params WIDTH, DEPTH; show-ahead, count output), instantiated twice:
//   cmd FIFO width U_ADDR_MSB+1+3, wd FIFO width U_DATA_MSB+1+4.
// TESTING
//  Write len=3 adr=0x100, 4 beats 0xA0..0xA3 -> one sdr_req, fields held till ack, 4 wr_next pop A0..A3.
//  Write cmd with only 2 of 4 beats queued -> no sdr_req until 4th beat pushed; then request issues.
//  Read len=1 adr=0x40, two sdr_rd_valid 0x11,0x22 -> hst_rd_valid 2 cycles, data 0x11,0x22, 1-cycle lag.
//  Push 4 cmds with sdr_init_done=0 -> hst_cmd_ready drops after 4th, 5th refused, no sdr_req until init_done.
//  sdr_wr_next with wd FIFO empty -> err_underrun=1 sticky, sdr_wr_en_n=4'hF, cleared only by reset.
//  Reset asserted mid WR_BURST (2 of 4 beats done) -> next cycle sdr_req=0, FIFOs empty, FSM IDLE.

Source files
------------

// File: rtl/sdc_host_if_pkg.sv
// Shared types and constants for the SDRAM controller host front end.
// Holds address/data widths, request length width, FSM encodings and FIFO entry layouts.
package sdc_host_if_pkg;

    localparam int unsigned U_ADDR_MSB = 21;
    localparam int unsigned U_DATA_MSB = 31;
    localparam int unsigned SDC_LEN_W  = 2;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StWrBurst = 2'd2,
        StRdBurst = 2'd3
    } sdc_state_e;

    typedef struct packed {
        logic [U_ADDR_MSB:0]    adr;
        logic [SDC_LEN_W-1:0]   len;
        logic                   wr_n;
    } sdc_cmd_t;

    typedef struct packed {
        logic [U_DATA_MSB:0]    data;
        logic [3:0]             en_n;
    } sdc_wd_t;

    localparam int unsigned CMD_W = $bits(sdc_cmd_t);
    localparam int unsigned WD_W  = $bits(sdc_wd_t);

    // Burst length code to beat count (1..4).
    function automatic logic [2:0] len_beats(input logic [SDC_LEN_W-1:0] len);
        return {1'b0, len} + 3'd1;
    endfunction

endpackage

// File: rtl/sdc_host_if_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and a registered not-full flag.
// Pushes are only taken while ready is high, so a full FIFO refuses a push even when popped.
module sdc_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ready
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && ready;
    assign do_pop  = pop && (count != '0);
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_d = count;
        if (do_push && !do_pop) begin
            count_d = count + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_d;
            ready <= (count_d != FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/sdc_host_if.sv
// Host request front end for sdc_top: queues commands and write beats, issues one request at a
// time, feeds write beats on sdr_wr_next and registers read beats back to the host.
module sdc_host_if
    import sdc_host_if_pkg::*;
#(
    parameter int unsigned CMD_DEPTH = 4,
    parameter int unsigned WD_DEPTH  = 16
) (
    input  logic                    mclk,
    input  logic                    s_resetn,
    input  logic                    hst_cmd_valid,
    output logic                    hst_cmd_ready,
    input  logic [U_ADDR_MSB:0]     hst_cmd_adr,
    input  logic [SDC_LEN_W-1:0]    hst_cmd_len,
    input  logic                    hst_cmd_wr_n,
    input  logic                    hst_wd_valid,
    output logic                    hst_wd_ready,
    input  logic [U_DATA_MSB:0]     hst_wd_data,
    input  logic [3:0]              hst_wd_en_n,
    output logic                    hst_rd_valid,
    output logic [U_DATA_MSB:0]     hst_rd_data,
    output logic                    err_underrun,
    output logic                    busy,
    input  logic                    sdr_init_done,
    output logic                    sdr_req,
    output logic [U_ADDR_MSB:0]     sdr_req_adr,
    output logic [SDC_LEN_W-1:0]    sdr_req_len,
    output logic                    sdr_req_wr_n,
    input  logic                    sdr_req_ack,
    input  logic                    sdr_wr_next,
    output logic [U_DATA_MSB:0]     sdr_wr_data,
    output logic [3:0]              sdr_wr_en_n,
    input  logic                    sdr_rd_valid,
    input  logic [U_DATA_MSB:0]     sdr_rd_data
);

    localparam int unsigned CMD_CNT_W = $clog2(CMD_DEPTH) + 1;
    localparam int unsigned WD_CNT_W  = $clog2(WD_DEPTH) + 1;

    sdc_cmd_t               cmd_in;
    sdc_cmd_t               cmd_head;
    sdc_wd_t                wd_in;
    sdc_wd_t                wd_head;
    logic [CMD_CNT_W-1:0]   cmd_count;
    logic [WD_CNT_W-1:0]    wd_count;
    logic                   cmd_empty;
    logic                   wd_empty;
    logic                   start;
    logic                   wd_pop;
    sdc_state_e             state;
    logic [2:0]             beat_cnt;

    assign cmd_in = '{adr: hst_cmd_adr, len: hst_cmd_len, wr_n: hst_cmd_wr_n};
    assign wd_in  = '{data: hst_wd_data, en_n: hst_wd_en_n};

    sdc_sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk   (mclk),
        .rst_n (s_resetn),
        .push  (hst_cmd_valid),
        .wdata (cmd_in),
        .pop   (start),
        .rdata (cmd_head),
        .count (cmd_count),
        .ready (hst_cmd_ready)
    );

    sdc_sync_fifo #(
        .WIDTH (WD_W),
        .DEPTH (WD_DEPTH)
    ) u_wd_fifo (
        .clk   (mclk),
        .rst_n (s_resetn),
        .push  (hst_wd_valid),
        .wdata (wd_in),
        .pop   (wd_pop),
        .rdata (wd_head),
        .count (wd_count),
        .ready (hst_wd_ready)
    );

    assign cmd_empty = (cmd_count == '0);
    assign wd_empty  = (wd_count == '0);
    assign wd_pop    = sdr_wr_next && !wd_empty;

    // A write is only launched once its whole burst is already queued, so it cannot underrun.
    assign start = (state == StIdle) && sdr_init_done && !cmd_empty &&
                   (cmd_head.wr_n || (wd_count >= WD_CNT_W'(len_beats(cmd_head.len))));

    assign sdr_wr_data = wd_empty ? '0    : wd_head.data;
    assign sdr_wr_en_n = wd_empty ? 4'hF  : wd_head.en_n;
    assign busy        = (state != StIdle) || !cmd_empty;

    always_ff @(posedge mclk) begin
        if (!s_resetn) begin
            state        <= StIdle;
            sdr_req      <= 1'b0;
            sdr_req_adr  <= '0;
            sdr_req_len  <= '0;
            sdr_req_wr_n <= 1'b0;
            beat_cnt     <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state        <= StReq;
                        sdr_req      <= 1'b1;
                        sdr_req_adr  <= cmd_head.adr;
                        sdr_req_len  <= cmd_head.len;
                        sdr_req_wr_n <= cmd_head.wr_n;
                        beat_cnt     <= len_beats(cmd_head.len);
                    end
                end
                StReq: begin
                    if (sdr_req_ack) begin
                        sdr_req <= 1'b0;
                        state   <= sdr_req_wr_n ? StRdBurst : StWrBurst;
                    end
                end
                StWrBurst: begin
                    if (sdr_wr_next) begin
                        beat_cnt <= beat_cnt - 3'd1;
                        if (beat_cnt == 3'd1) state <= StIdle;
                    end
                end
                StRdBurst: begin
                    if (sdr_rd_valid) begin
                        beat_cnt <= beat_cnt - 3'd1;
                        if (beat_cnt == 3'd1) state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge mclk) begin
        if (!s_resetn) begin
            err_underrun <= 1'b0;
        end else if (sdr_wr_next && wd_empty) begin
            err_underrun <= 1'b1;
        end
    end

    always_ff @(posedge mclk) begin
        if (!s_resetn) begin
            hst_rd_valid <= 1'b0;
            hst_rd_data  <= '0;
        end else begin
            hst_rd_valid <= sdr_rd_valid;
            hst_rd_data  <= sdr_rd_data;
        end
    end

endmodule

// File: tb/tb_sdc_host_if.sv
// Directed bench for sdc_host_if: a per-cycle vector table for a write and a read burst, plus
// hand-written sequences for partial write data, a full command FIFO, underrun and reset.
module tb_sdc_host_if;
    import sdc_host_if_pkg::*;

    localparam int unsigned AW = U_ADDR_MSB + 1;
    localparam int unsigned DW = U_DATA_MSB + 1;

    logic          mclk = 1'b0;
    logic          s_resetn;
    logic          hst_cmd_valid, hst_cmd_ready, hst_cmd_wr_n;
    logic [AW-1:0] hst_cmd_adr;
    logic [1:0]    hst_cmd_len;
    logic          hst_wd_valid, hst_wd_ready;
    logic [DW-1:0] hst_wd_data;
    logic [3:0]    hst_wd_en_n;
    logic          hst_rd_valid;
    logic [DW-1:0] hst_rd_data;
    logic          err_underrun, busy, sdr_init_done;
    logic          sdr_req, sdr_req_wr_n, sdr_req_ack, sdr_wr_next, sdr_rd_valid;
    logic [AW-1:0] sdr_req_adr;
    logic [1:0]    sdr_req_len;
    logic [DW-1:0] sdr_wr_data, sdr_rd_data;
    logic [3:0]    sdr_wr_en_n;

    always #5 mclk = ~mclk;

    sdc_host_if dut (
        .mclk          (mclk),
        .s_resetn      (s_resetn),
        .hst_cmd_valid (hst_cmd_valid),
        .hst_cmd_ready (hst_cmd_ready),
        .hst_cmd_adr   (hst_cmd_adr),
        .hst_cmd_len   (hst_cmd_len),
        .hst_cmd_wr_n  (hst_cmd_wr_n),
        .hst_wd_valid  (hst_wd_valid),
        .hst_wd_ready  (hst_wd_ready),
        .hst_wd_data   (hst_wd_data),
        .hst_wd_en_n   (hst_wd_en_n),
        .hst_rd_valid  (hst_rd_valid),
        .hst_rd_data   (hst_rd_data),
        .err_underrun  (err_underrun),
        .busy          (busy),
        .sdr_init_done (sdr_init_done),
        .sdr_req       (sdr_req),
        .sdr_req_adr   (sdr_req_adr),
        .sdr_req_len   (sdr_req_len),
        .sdr_req_wr_n  (sdr_req_wr_n),
        .sdr_req_ack   (sdr_req_ack),
        .sdr_wr_next   (sdr_wr_next),
        .sdr_wr_data   (sdr_wr_data),
        .sdr_wr_en_n   (sdr_wr_en_n),
        .sdr_rd_valid  (sdr_rd_valid),
        .sdr_rd_data   (sdr_rd_data)
    );

    typedef struct {
        logic          cv;
        logic [AW-1:0] adr;
        logic [1:0]    len;
        logic          wrn;
        logic          wv;
        logic [DW-1:0] wd;
        logic          wnx;
        logic          ack;
        logic          rv;
        logic [DW-1:0] rd;
        logic          e_req;
        logic [AW-1:0] e_adr;
        logic          e_wrn;
        logic [DW-1:0] e_wd;
        logic          e_busy;
        logic          e_rv;
        logic [DW-1:0] e_rd;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;
    vec_t vecs[$];
    logic any_req;
    logic [3:0] en_tab [4];

    function automatic vec_t mk(input int cv, input int adr, input int len, input int wrn,
                                input int wv, input int wd, input int wnx, input int ack,
                                input int rv, input int rd, input int e_req, input int e_adr,
                                input int e_wrn, input int e_wd, input int e_busy,
                                input int e_rv, input int e_rd);
        vec_t v;
        v.cv = 1'(cv);      v.adr = AW'(adr);     v.len = 2'(len);     v.wrn = 1'(wrn);
        v.wv = 1'(wv);      v.wd = DW'(wd);       v.wnx = 1'(wnx);     v.ack = 1'(ack);
        v.rv = 1'(rv);      v.rd = DW'(rd);       v.e_req = 1'(e_req); v.e_adr = AW'(e_adr);
        v.e_wrn = 1'(e_wrn); v.e_wd = DW'(e_wd);  v.e_busy = 1'(e_busy);
        v.e_rv = 1'(e_rv);  v.e_rd = DW'(e_rd);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic drive_idle();
        hst_cmd_valid = 1'b0; hst_cmd_adr = '0; hst_cmd_len = '0; hst_cmd_wr_n = 1'b0;
        hst_wd_valid = 1'b0;  hst_wd_data = '0; hst_wd_en_n = 4'h0;
        sdr_req_ack = 1'b0;   sdr_wr_next = 1'b0; sdr_rd_valid = 1'b0; sdr_rd_data = '0;
    endtask

    task automatic wait_req(input string name, input int budget);
        int n = 0;
        while (!sdr_req && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(sdr_req), 32'd1);
    endtask

    task automatic watch_no_req(input int cycles);
        any_req = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (sdr_req) any_req = 1'b1;
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        en_tab = '{4'h1, 4'h2, 4'h4, 4'h8};
        //            cv adr   ln wn wv wd    wx ak rv rd    req eadr  ewn ewd   bsy erv erd
        vecs.push_back(mk(1, 'h100, 3, 0, 1, 'hA0, 0, 0, 0, 0,    0, 0,     0, 0,    0, 0, 0));
        vecs.push_back(mk(0, 0,     0, 0, 1, 'hA1, 0, 0, 0, 0,    0, 0,     0, 'hA0, 1, 0, 0));
        vecs.push_back(mk(0, 0,     0, 0, 1, 'hA2, 0, 0, 0, 0,    0, 0,     0, 'hA0, 1, 0, 0));
        vecs.push_back(mk(0, 0,     0, 0, 1, 'hA3, 0, 0, 0, 0,    0, 0,     0, 'hA0, 1, 0, 0));
        vecs.push_back(mk(0, 0,     0, 0, 0, 0,    0, 0, 0, 0,    0, 0,     0, 'hA0, 1, 0, 0));
        vecs.push_back(mk(0, 0,     0, 0, 0, 0,    0, 0, 0, 0,    1, 'h100, 0, 'hA0, 1, 0, 0));
        vecs.push_back(mk(0, 0,     0, 0, 0, 0,    0, 1, 0, 0,    1, 'h100, 0, 'hA0, 1, 0, 0));
        vecs.push_back(mk(0, 0,     0, 0, 0, 0,    1, 0, 0, 0,    0, 0,     0, 'hA0, 1, 0, 0));
        vecs.push_back(mk(0, 0,     0, 0, 0, 0,    1, 0, 0, 0,    0, 0,     0, 'hA1, 1, 0, 0));
        vecs.push_back(mk(0, 0,     0, 0, 0, 0,    1, 0, 0, 0,    0, 0,     0, 'hA2, 1, 0, 0));
        vecs.push_back(mk(0, 0,     0, 0, 0, 0,    1, 0, 0, 0,    0, 0,     0, 'hA3, 1, 0, 0));
        vecs.push_back(mk(1, 'h40,  1, 1, 0, 0,    0, 0, 0, 0,    0, 0,     0, 0,    0, 0, 0));
        vecs.push_back(mk(0, 0,     0, 0, 0, 0,    0, 0, 0, 0,    0, 0,     0, 0,    1, 0, 0));
        vecs.push_back(mk(0, 0,     0, 0, 0, 0,    0, 1, 0, 0,    1, 'h40,  1, 0,    1, 0, 0));
        vecs.push_back(mk(0, 0,     0, 0, 0, 0,    0, 0, 1, 'h11, 0, 0,     0, 0,    1, 0, 0));
        vecs.push_back(mk(0, 0,     0, 0, 0, 0,    0, 0, 1, 'h22, 0, 0,     0, 0,    1, 1, 'h11));
        vecs.push_back(mk(0, 0,     0, 0, 0, 0,    0, 0, 0, 0,    0, 0,     0, 0,    0, 1, 'h22));
        vecs.push_back(mk(0, 0,     0, 0, 0, 0,    0, 0, 0, 0,    0, 0,     0, 0,    0, 0, 0));

        // Reset state
        drive_idle();
        sdr_init_done = 1'b1;
        s_resetn = 1'b0;
        tick();
        tick();
        check("rst_cmd_ready", 32'(hst_cmd_ready), 32'd0);
        check("rst_wd_ready", 32'(hst_wd_ready), 32'd0);
        check("rst_req", 32'(sdr_req), 32'd0);
        check("rst_rd_valid", 32'(hst_rd_valid), 32'd0);
        check("rst_rd_data", hst_rd_data, 32'd0);
        check("rst_underrun", 32'(err_underrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_en_n", 32'(sdr_wr_en_n), 32'hF);
        s_resetn = 1'b1;
        tick();
        check("post_rst_cmd_ready", 32'(hst_cmd_ready), 32'd1);
        check("post_rst_wd_ready", 32'(hst_wd_ready), 32'd1);

        // Per-cycle table: write burst then read burst
        for (int i = 0; i < vecs.size(); i++) begin
            hst_cmd_valid = vecs[i].cv;  hst_cmd_adr = vecs[i].adr;
            hst_cmd_len = vecs[i].len;   hst_cmd_wr_n = vecs[i].wrn;
            hst_wd_valid = vecs[i].wv;   hst_wd_data = vecs[i].wd;  hst_wd_en_n = 4'h0;
            sdr_wr_next = vecs[i].wnx;   sdr_req_ack = vecs[i].ack;
            sdr_rd_valid = vecs[i].rv;   sdr_rd_data = vecs[i].rd;
            check($sformatf("v%0d_req", i), 32'(sdr_req), 32'(vecs[i].e_req));
            if (vecs[i].e_req) begin
                check($sformatf("v%0d_adr", i), 32'(sdr_req_adr), 32'(vecs[i].e_adr));
                check($sformatf("v%0d_wr_n", i), 32'(sdr_req_wr_n), 32'(vecs[i].e_wrn));
            end
            check($sformatf("v%0d_wr_data", i), sdr_wr_data, vecs[i].e_wd);
            check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            check($sformatf("v%0d_rd_valid", i), 32'(hst_rd_valid), 32'(vecs[i].e_rv));
            if (vecs[i].e_rv) check($sformatf("v%0d_rd_data", i), hst_rd_data, vecs[i].e_rd);
            tick();
        end
        drive_idle();

        // Write command held back until all four beats are queued
        hst_cmd_valid = 1'b1; hst_cmd_adr = AW'(32'h200); hst_cmd_len = 2'd3; hst_cmd_wr_n = 1'b0;
        hst_wd_valid = 1'b1;  hst_wd_data = 32'hB0;       hst_wd_en_n = en_tab[0];
        tick();
        hst_cmd_valid = 1'b0; hst_wd_data = 32'hB1; hst_wd_en_n = en_tab[1];
        tick();
        hst_wd_valid = 1'b0;
        watch_no_req(6);
        check("partial_no_req", 32'(any_req), 32'd0);
        hst_wd_valid = 1'b1; hst_wd_data = 32'hB2; hst_wd_en_n = en_tab[2];
        tick();
        hst_wd_data = 32'hB3; hst_wd_en_n = en_tab[3];
        tick();
        hst_wd_valid = 1'b0;
        wait_req("partial_req_seen", 10);
        check("partial_adr", 32'(sdr_req_adr), 32'h200);
        check("partial_len", 32'(sdr_req_len), 32'd3);
        sdr_req_ack = 1'b1;
        tick();
        sdr_req_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("partial_beat%0d_data", i), sdr_wr_data, 32'hB0 + 32'(i));
            check($sformatf("partial_beat%0d_en_n", i), 32'(sdr_wr_en_n), 32'(en_tab[i]));
            sdr_wr_next = 1'b1;
            tick();
        end
        sdr_wr_next = 1'b0;
        check("partial_done_busy", 32'(busy), 32'd0);
        check("partial_no_underrun", 32'(err_underrun), 32'd0);

        // Command FIFO fills while the controller is not initialised
        sdr_init_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fill%0d_ready", i), 32'(hst_cmd_ready), 32'd1);
            hst_cmd_valid = 1'b1; hst_cmd_adr = AW'(32'h10 + 32'(i));
            hst_cmd_len = 2'd0;   hst_cmd_wr_n = 1'b1;
            tick();
        end
        check("full_ready_low", 32'(hst_cmd_ready), 32'd0);
        hst_cmd_adr = AW'(32'h99);
        watch_no_req(3);
        check("full_no_req", 32'(any_req), 32'd0);
        check("full_busy", 32'(busy), 32'd1);
        hst_cmd_valid = 1'b0;
        sdr_init_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_req($sformatf("drain%0d_req_seen", i), 10);
            check($sformatf("drain%0d_adr", i), 32'(sdr_req_adr), 32'h10 + 32'(i));
            sdr_req_ack = 1'b1;
            tick();
            sdr_req_ack = 1'b0;
            sdr_rd_valid = 1'b1; sdr_rd_data = 32'h50 + 32'(i);
            tick();
            sdr_rd_valid = 1'b0;
            check($sformatf("drain%0d_rd_valid", i), 32'(hst_rd_valid), 32'd1);
            check($sformatf("drain%0d_rd_data", i), hst_rd_data, 32'h50 + 32'(i));
        end
        watch_no_req(6);
        check("fifth_refused", 32'(any_req), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);

        // Underrun with an empty write-data FIFO is sticky
        check("empty_en_n", 32'(sdr_wr_en_n), 32'hF);
        sdr_wr_next = 1'b1;
        tick();
        sdr_wr_next = 1'b0;
        check("underrun_set", 32'(err_underrun), 32'd1);
        tick(); tick(); tick();
        check("underrun_sticky", 32'(err_underrun), 32'd1);
        check("underrun_en_n", 32'(sdr_wr_en_n), 32'hF);

        // Reset in the middle of a write burst
        hst_cmd_valid = 1'b1; hst_cmd_adr = AW'(32'h300); hst_cmd_len = 2'd3; hst_cmd_wr_n = 1'b0;
        hst_wd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            hst_wd_data = 32'hC0 + 32'(i); hst_wd_en_n = 4'h0;
            tick();
            hst_cmd_valid = 1'b0;
        end
        hst_wd_valid = 1'b0;
        wait_req("midrst_req_seen", 10);
        sdr_req_ack = 1'b1;
        tick();
        sdr_req_ack = 1'b0;
        sdr_wr_next = 1'b1;
        tick();
        tick();
        sdr_wr_next = 1'b0;
        check("midrst_head", sdr_wr_data, 32'hC2);
        s_resetn = 1'b0;
        tick();
        check("midrst_req", 32'(sdr_req), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_wd_empty", 32'(sdr_wr_en_n), 32'hF);
        check("midrst_wr_data", sdr_wr_data, 32'd0);
        check("midrst_underrun_clr", 32'(err_underrun), 32'd0);
        check("midrst_cmd_ready", 32'(hst_cmd_ready), 32'd0);
        s_resetn = 1'b1;
        tick();
        check("midrst_cmd_ready_back", 32'(hst_cmd_ready), 32'd1);
        check("midrst_wd_ready_back", 32'(hst_wd_ready), 32'd1);
        watch_no_req(5);
        check("midrst_no_req", 32'(any_req), 32'd0);
        check("midrst_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
